// File: rtl/word_alu_sched.sv
// Shared multi-cycle W-bit arithmetic unit for NREQ requesters.
// Round-robin arbitration, one operation in flight; iterative DIV/MOD and POW.
module word_alu_sched #(
  parameter int NREQ = 2,
  parameter int W    = 8,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err
);

  localparam int CW = $clog2(W);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2,
                         OP_DIV = 3'd3, OP_MOD = 3'd4, OP_POW = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] ptr, grant, id;
  logic           found;
  int             idx;
  logic [2:0]     op;
  logic [W-1:0]   a, b, acc, quo, rem;
  logic [CW-1:0]  cnt;
  logic           short_op, b_zero;
  logic [W:0]     shifted, diff;
  logic [W-1:0]   rem_nx, quo_nx, sq, acc_nx, res;
  logic           res_err;

  // Round-robin grant: first valid requester at or after ptr
  always_comb begin
    grant = {IDW{1'b0}};
    found = 1'b0;
    idx   = 0;
    for (int j = 0; j < NREQ; j++) begin
      idx = (int'(ptr) + j) % NREQ;
      if (!found && req_valid[idx]) begin
        grant = IDW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (found) state_nx = EXEC; else state_nx = IDLE;
      EXEC: if (short_op || cnt == {CW{1'b0}}) state_nx = DONE; else state_nx = EXEC;
      DONE: if (rsp_ready) state_nx = IDLE; else state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs; nothing is offered while reset is asserted
  always_comb begin
    req_ready = {NREQ{1'b0}};
    if (state == IDLE && found && !rst) begin
      req_ready[grant] = 1'b1;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
    rsp_valid = (state == DONE) && !rst;
  end

  // One restoring-divide step and one square-and-multiply step, plus final result
  always_comb begin
    b_zero   = (b == {W{1'b0}});
    short_op = !(((op == OP_DIV) || (op == OP_MOD)) && !b_zero) && (op != OP_POW);
    shifted  = {rem, quo[W-1]};
    diff     = shifted - {1'b0, b};
    if (shifted >= {1'b0, b}) begin
      rem_nx = diff[W-1:0];
      quo_nx = {quo[W-2:0], 1'b1};
    end else begin
      rem_nx = shifted[W-1:0];
      quo_nx = {quo[W-2:0], 1'b0};
    end
    sq     = acc * acc;
    acc_nx = b[cnt] ? sq * a : sq;
    res_err = 1'b0;
    case (op)
      OP_ADD: res = a + b;
      OP_SUB: res = a - b;
      OP_MUL: res = a * b;
      OP_DIV: begin res = b_zero ? {W{1'b1}} : quo_nx; res_err = b_zero; end
      OP_MOD: begin res = b_zero ? a : rem_nx;         res_err = b_zero; end
      OP_POW: res = acc_nx;
      default: begin res = {W{1'b0}}; res_err = 1'b1; end
    endcase
  end

  // Operand latch, iteration registers and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= {IDW{1'b0}};
      id       <= {IDW{1'b0}};
      op       <= 3'd0;
      a        <= {W{1'b0}};
      b        <= {W{1'b0}};
      acc      <= {W{1'b0}};
      quo      <= {W{1'b0}};
      rem      <= {W{1'b0}};
      cnt      <= {CW{1'b0}};
      rsp_id   <= {IDW{1'b0}};
      rsp_data <= {W{1'b0}};
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op  <= req_op[3*int'(grant) +: 3];
            a   <= req_a[W*int'(grant) +: W];
            b   <= req_b[W*int'(grant) +: W];
            id  <= grant;
            ptr <= IDW'((int'(grant) + 1) % NREQ);
            acc <= W'(1);
            rem <= {W{1'b0}};
            quo <= req_a[W*int'(grant) +: W];
            cnt <= CW'(W - 1);
          end
        end
        EXEC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          acc <= acc_nx;
          cnt <= cnt - CW'(1);
          if (short_op || cnt == {CW{1'b0}}) begin
            rsp_data <= res;
            rsp_err  <= res_err;
            rsp_id   <= id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_word_alu_sched.sv
// Randomized + directed bench for word_alu_sched against an arithmetic reference model.
module tb_word_alu_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [5:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [0:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;

  word_alu_sched #(.NREQ(2), .W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  bit pend[2];
  int p_op[2], p_a[2], p_b[2];
  int tb_ptr = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions
  function automatic void ref_calc(input int op, input int a, input int b,
                                   output int d, output bit e, output int k);
    e = 1'b0;
    k = 1;
    case (op)
      0: d = (a + b) % 256;
      1: d = (a - b + 256) % 256;
      2: d = (a * b) % 256;
      3: begin if (b == 0) begin d = 255; e = 1'b1; end else begin d = a / b; k = 8; end end
      4: begin if (b == 0) begin d = a;   e = 1'b1; end else begin d = a % b; k = 8; end end
      5: begin d = 1; for (int i = 0; i < b; i++) d = (d * a) % 256; k = 8; end
      default: begin d = 0; e = 1'b1; end
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      req_valid[i]     = pend[i];
      req_op[3*i +: 3] = p_op[i][2:0];
      req_a[8*i +: 8]  = p_a[i][7:0];
      req_b[8*i +: 8]  = p_b[i][7:0];
    end
  endtask

  task automatic set_req(input int r, input int op, input int a, input int b);
    pend[r] = 1'b1; p_op[r] = op; p_a[r] = a; p_b[r] = b;
  endtask

  // Completes one transaction; called and returns at a negedge
  task automatic serve(input int stall);
    int n, g, t0, ed, k, exp_g;
    bit ee;
    drive(); #1;
    n = 0;
    while (req_ready == 2'b00 && n < 40) begin @(negedge clk); drive(); #1; n++; end
    if (req_ready == 2'b00) begin check("grant_timeout", 0, 1); return; end
    g = req_ready[1] ? 1 : 0;
    check("ready_onehot", $countones(req_ready), 1);
    exp_g = pend[tb_ptr] ? tb_ptr : 1 - tb_ptr;
    check("grant_id", g, exp_g);
    t0 = cyc;
    ref_calc(p_op[g], p_a[g], p_b[g], ed, ee, k);
    pend[g] = 1'b0;
    tb_ptr = (g + 1) % 2;
    @(negedge clk); drive();
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("rsp_latency", cyc - t0, 1 + k);
    check("rsp_id", int'(rsp_id), g);
    check("rsp_data", int'(rsp_data), ed);
    check("rsp_err", int'(rsp_err), int'(ee));
    repeat (stall) begin
      @(negedge clk); drive(); #1;
      check("stall_ready", int'(req_ready), 0);
      check("stall_valid", int'(rsp_valid), 1);
      check("stall_id", int'(rsp_id), g);
      check("stall_data", int'(rsp_data), ed);
      check("stall_err", int'(rsp_err), int'(ee));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", int'(rsp_valid), 0);
  endtask

  initial begin
    int n, seen;
    rst = 1'b1; rsp_ready = 1'b0;
    set_req(0, 0, 1, 1); set_req(1, 0, 2, 2);
    drive();
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", int'(req_ready), 0);
    check("reset_valid", int'(rsp_valid), 0);
    check("reset_id", int'(rsp_id), 0);
    check("reset_data", int'(rsp_data), 0);
    check("reset_err", int'(rsp_err), 0);
    @(negedge clk);
    rst = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0; drive();
    @(negedge clk);

    set_req(0, 0, 200, 100); serve(0);
    set_req(0, 1, 5, 7);     serve(0);
    set_req(1, 2, 20, 13);   serve(0);
    set_req(0, 0, 1, 2); set_req(1, 1, 3, 4); serve(0); serve(0);
    set_req(0, 2, 9, 9); set_req(1, 0, 8, 8); serve(0); serve(0);
    set_req(0, 3, 200, 7); serve(0);
    set_req(1, 4, 200, 7); serve(0);
    set_req(0, 3, 9, 0);   serve(0);
    set_req(1, 4, 9, 0);   serve(0);
    set_req(0, 5, 3, 5);   serve(0);
    set_req(0, 5, 2, 8);   serve(0);
    set_req(1, 5, 7, 0);   serve(0);
    set_req(0, 6, 11, 3);  serve(0);
    set_req(1, 7, 11, 3);  serve(0);
    set_req(0, 3, 100, 3); set_req(1, 0, 1, 1); serve(5); serve(0);

    for (int it = 0; it < 200; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(1, 0) == 1)
          set_req(r, $urandom_range(7, 0), $urandom_range(255, 0),
                  ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(255, 0));
      end
      if (!pend[0] && !pend[1]) set_req(it % 2, $urandom_range(5, 0), $urandom_range(255, 0), $urandom_range(255, 0));
      serve($urandom_range(2, 0));
    end
    while (pend[0] || pend[1]) serve(0);

    // Reset during the 4th EXEC cycle of a DIV issued by req0 (leaves ptr at 1)
    set_req(0, 3, 200, 7);
    drive(); #1;
    check("abort_grant", int'(req_ready), 1);
    pend[0] = 1'b0;
    repeat (4) begin @(negedge clk); drive(); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tb_ptr = 0;
    check("abort_valid", int'(rsp_valid), 0);
    seen = 0;
    repeat (12) begin @(negedge clk); if (rsp_valid) seen = 1; end
    check("abort_no_rsp", seen, 0);
    set_req(0, 0, 3, 4); set_req(1, 0, 5, 6); serve(0); serve(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
